dw_up_conv_arbiter: RTL and testbench

Shares one `dw_up_converter` input port among NUM_REQ narrow requesters. Grants are round-robin and locked per packing group: a winner owns the converter for exactly UP_RATIO input handshakes, so one wide output beat never mixes words from different requesters. Sits directly upstream of the converter's `data_i/valid_i/ready_o` port.

---
 rtl/dw_up_conv_arbiter.sv | 121 ++++++++++++
 tb/tb_dw_up_conv_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dw_up_conv_arbiter.sv
// Round-robin arbiter that shares one up-converter input among NUM_REQ narrow
// requesters, locking each grant for a full UP_RATIO-word packing group.
module dw_up_conv_arbiter #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned INPUT_DW  = 64,
   parameter int unsigned OUTPUT_DW = 512,
   parameter int unsigned UP_RATIO  = OUTPUT_DW / INPUT_DW,
   parameter int unsigned IDX_W     = $clog2(NUM_REQ),
   parameter int unsigned CNT_W     = $clog2(UP_RATIO)
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [NUM_REQ*INPUT_DW-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]          req_valid_i,
   output logic [NUM_REQ-1:0]          req_ready_o,
   output logic [INPUT_DW-1:0]         conv_data_o,
   output logic                        conv_valid_o,
   input  logic                        conv_ready_i,
   output logic [IDX_W-1:0]            grant_idx_o,
   output logic [CNT_W-1:0]            word_cnt_o,
   output logic                        busy_o
);

   if (OUTPUT_DW % INPUT_DW != 0) begin : g_chk_dw
      $fatal(1, "OUTPUT_DW must be a multiple of INPUT_DW");
   end
   if (UP_RATIO < 2 || (UP_RATIO & (UP_RATIO - 1)) != 0) begin : g_chk_ratio
      $fatal(1, "UP_RATIO must be a power of two and at least 2");
   end
   if (NUM_REQ < 2) begin : g_chk_req
      $fatal(1, "NUM_REQ must be at least 2");
   end

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t              state, state_d;
   logic [IDX_W-1:0]    grant_q, grant_d;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    pick, cand, next_ptr;
   logic                found;
   logic                hs;
   logic [INPUT_DW-1:0] words [NUM_REQ];

   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         words[i] = req_data_i[i*INPUT_DW +: INPUT_DW];
      end
   end

   // First valid requester at or above rr_ptr_q, wrapping past NUM_REQ-1.
   always_comb begin
      found = 1'b0;
      pick  = rr_ptr_q;
      cand  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = IDX_W'((32'(rr_ptr_q) + i) % NUM_REQ);
         if (!found && req_valid_i[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign next_ptr = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);

   always_comb begin
      state_d      = state;
      grant_d      = grant_q;
      rr_ptr_d     = rr_ptr_q;
      cnt_d        = cnt_q;
      conv_valid_o = 1'b0;
      req_ready_o  = '0;
      busy_o       = 1'b0;
      hs           = 1'b0;
      unique case (state)
         IDLE: begin
            if (found) begin
               grant_d = pick;
               cnt_d   = '0;
               state_d = LOCKED;
            end
         end
         LOCKED: begin
            busy_o               = 1'b1;
            conv_valid_o         = req_valid_i[grant_q];
            req_ready_o[grant_q] = conv_ready_i;
            hs                   = req_valid_i[grant_q] & conv_ready_i;
            if (hs) begin
               if (cnt_q == CNT_W'(UP_RATIO - 1)) begin
                  cnt_d    = '0;
                  rr_ptr_d = next_ptr;
                  state_d  = IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         state    <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign conv_data_o = words[grant_q];
   assign grant_idx_o = grant_q;
   assign word_cnt_o  = cnt_q;

endmodule

// File: tb/tb_dw_up_conv_arbiter.sv
// Self-checking bench for dw_up_conv_arbiter: arbitration table plus hand-written
// sequences, with a queue scoreboard checking every converter-side beat.
module tb_dw_up_conv_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int INPUT_DW  = 64;
   localparam int OUTPUT_DW = 512;
   localparam int RATIO     = 8;

   logic                        clk;
   logic                        rst_n;
   logic [NUM_REQ*INPUT_DW-1:0] req_data;
   logic [NUM_REQ-1:0]          req_valid;
   logic [NUM_REQ-1:0]          req_ready;
   logic [INPUT_DW-1:0]         conv_data;
   logic                        conv_valid;
   logic                        conv_ready;
   logic [1:0]                  grant_idx;
   logic [2:0]                  word_cnt;
   logic                        busy;

   dw_up_conv_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .INPUT_DW (INPUT_DW),
      .OUTPUT_DW(OUTPUT_DW)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_data_i  (req_data),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .conv_data_o (conv_data),
      .conv_valid_o(conv_valid),
      .conv_ready_i(conv_ready),
      .grant_idx_o (grant_idx),
      .word_cnt_o  (word_cnt),
      .busy_o      (busy)
   );

   typedef struct {
      logic [3:0] mask;
      logic [1:0] grant;
      logic [3:0] ready;
   } vec_t;

   vec_t              tbl [12];
   int                cur [NUM_REQ];
   logic [63:0]       exp_q [$];
   logic [NUM_REQ-1:0] hs;
   int                n_cmp = 0;
   int                n_err = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] word(input int r, input int s);
      return {8'(r), 24'hA5A5A5, 32'(s)};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_data();
      for (int r = 0; r < NUM_REQ; r++) req_data[r*INPUT_DW +: INPUT_DW] = word(r, cur[r]);
   endtask

   task automatic push_group(input int r, input int n);
      for (int k = 0; k < n; k++) exp_q.push_back(word(r, cur[r] + k));
   endtask

   // One clock: scoreboard the converter beat at the falling edge, then advance
   // each requester's stream after the rising edge that consumed its word.
   task automatic tick();
      @(negedge clk);
      if (conv_valid && conv_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL beat_unexpected: got %0h expected no beat at %0t", conv_data, $time);
         end else begin
            chk("beat_data", conv_data, exp_q.pop_front());
         end
      end
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int r = 0; r < NUM_REQ; r++) if (hs[r]) cur[r]++;
      drive_data();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"}, 64'(busy), 64'(0));
      chk({tag, "_cvalid"}, 64'(conv_valid), 64'(0));
      chk({tag, "_rready"}, 64'(req_ready), 64'(0));
      chk({tag, "_grant"}, 64'(grant_idx), 64'(0));
      chk({tag, "_wcnt"}, 64'(word_cnt), 64'(0));
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("rst");
      ticks(2);
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      tbl = '{
         '{4'b1111, 2'd0, 4'b0001}, '{4'b1111, 2'd1, 4'b0010},
         '{4'b1111, 2'd2, 4'b0100}, '{4'b1111, 2'd3, 4'b1000},
         '{4'b1111, 2'd0, 4'b0001}, '{4'b1000, 2'd3, 4'b1000},
         '{4'b1001, 2'd0, 4'b0001}, '{4'b1001, 2'd3, 4'b1000},
         '{4'b0110, 2'd1, 4'b0010}, '{4'b0010, 2'd1, 4'b0010},
         '{4'b1100, 2'd2, 4'b0100}, '{4'b0101, 2'd0, 4'b0001}
      };
      for (int r = 0; r < NUM_REQ; r++) cur[r] = 0;
      rst_n      = 1'b1;
      req_valid  = '0;
      conv_ready = 1'b0;
      drive_data();
      #3;

      // Single requester streaming two groups
      reset_dut();
      req_valid  = 4'b0100;
      conv_ready = 1'b1;
      push_group(2, 16);
      #1;
      chk("s1_idle_rready", 64'(req_ready), 64'(0));
      chk("s1_idle_cvalid", 64'(conv_valid), 64'(0));
      tick();
      for (int g = 0; g < 2; g++) begin
         for (int k = 0; k < RATIO; k++) begin
            #1;
            chk("s1_busy", 64'(busy), 64'(1));
            chk("s1_grant", 64'(grant_idx), 64'(2));
            chk("s1_wcnt", 64'(word_cnt), 64'(k));
            tick();
         end
         #1;
         chk("s1_bubble", 64'(busy), 64'(0));
         chk("s1_last_owner", 64'(grant_idx), 64'(2));
         if (g == 0) tick();
      end
      req_valid = '0;
      tick();
      #1;
      chk("s1_stay_idle", 64'(busy), 64'(0));
      chk("s1_drain", 64'(exp_q.size()), 64'(0));

      // Arbitration table: fairness, pointer wrap, sparse request masks
      reset_dut();
      conv_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         req_valid = tbl[i].mask;
         #1;
         chk("tb_idle_busy", 64'(busy), 64'(0));
         chk("tb_idle_rready", 64'(req_ready), 64'(0));
         push_group(int'(tbl[i].grant), RATIO);
         tick();
         #1;
         chk("tb_grant", 64'(grant_idx), 64'(tbl[i].grant));
         chk("tb_rready", 64'(req_ready), 64'(tbl[i].ready));
         chk("tb_cvalid", 64'(conv_valid), 64'(1));
         chk("tb_wcnt0", 64'(word_cnt), 64'(0));
         ticks(RATIO - 1);
         #1;
         chk("tb_wcnt7", 64'(word_cnt), 64'(RATIO - 1));
         tick();
         #1;
         chk("tb_done", 64'(busy), 64'(0));
      end
      req_valid = '0;
      chk("tb_drain", 64'(exp_q.size()), 64'(0));

      // Lock integrity: owner r1 pauses mid-group while r0 and r3 wait
      reset_dut();
      conv_ready = 1'b1;
      req_valid  = 4'b0010;
      push_group(1, RATIO);
      tick();
      req_valid = 4'b1011;
      #1;
      chk("s3_grant", 64'(grant_idx), 64'(1));
      ticks(3);
      req_valid = 4'b1001;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("s3_gap_cvalid", 64'(conv_valid), 64'(0));
         chk("s3_gap_rready", 64'(req_ready), 64'(4'b0010));
         chk("s3_gap_wcnt", 64'(word_cnt), 64'(3));
         chk("s3_gap_busy", 64'(busy), 64'(1));
         tick();
      end
      req_valid = 4'b1011;
      for (int k = 3; k < RATIO; k++) begin
         #1;
         chk("s3_wcnt", 64'(word_cnt), 64'(k));
         tick();
      end
      #1;
      chk("s3_bubble", 64'(busy), 64'(0));
      push_group(3, RATIO);
      tick();
      #1;
      chk("s3_next_grant", 64'(grant_idx), 64'(3));
      ticks(RATIO);
      req_valid = '0;
      chk("s3_drain", 64'(exp_q.size()), 64'(0));

      // Backpressure: converter ready alternates each cycle
      reset_dut();
      req_valid  = 4'b0001;
      conv_ready = 1'b1;
      push_group(0, RATIO);
      tick();
      begin
         int acc;
         int i;
         acc = 0;
         i   = 0;
         while (acc < RATIO && i < 40) begin
            conv_ready = (i % 2 == 0);
            #1;
            chk("s4_wcnt", 64'(word_cnt), 64'(acc));
            chk("s4_rready", 64'(req_ready), 64'({3'b000, conv_ready}));
            tick();
            if (conv_ready) acc++;
            i++;
         end
         #1;
         chk("s4_cycles", 64'(i), 64'(2 * RATIO - 1));
      end
      req_valid = '0;
      #1;
      chk("s4_done", 64'(busy), 64'(0));
      chk("s4_drain", 64'(exp_q.size()), 64'(0));

      // Reset mid-group aborts it and restarts the round-robin pointer
      reset_dut();
      conv_ready = 1'b1;
      req_valid  = 4'b0001;
      push_group(0, RATIO);
      tick();
      ticks(RATIO);
      req_valid = 4'b1111;
      push_group(1, 5);
      tick();
      ticks(5);
      #1;
      chk("s6_grant", 64'(grant_idx), 64'(1));
      chk("s6_wcnt", 64'(word_cnt), 64'(5));
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("s6_abort");
      ticks(2);
      rst_n = 1'b1;
      #1;
      chk("s6_release_busy", 64'(busy), 64'(0));
      push_group(0, RATIO);
      tick();
      #1;
      chk("s6_first_grant", 64'(grant_idx), 64'(0));
      ticks(RATIO);
      req_valid = '0;
      chk("s6_drain", 64'(exp_q.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
